// File: rtl/fifo_32bit_apb3_drain.sv
// APB3 read-only initiator that polls a remote FIFO's flag register and drains
// words from its data register into a local sink FIFO.
module fifo_32bit_apb3_drain #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        ENABLE,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic        FULL,
    output logic        WREN,
    output logic [31:0] DATAOUT,
    output logic        ERR,
    output logic [15:0] WORDCOUNT
);

    typedef enum logic [2:0] {
        IDLE,
        FLAG_SETUP,
        FLAG_ACCESS,
        DATA_SETUP,
        DATA_ACCESS,
        PUSH,
        GAP
    } state_t;

    // A zero-length gap still spends one cycle in GAP.
    localparam int unsigned GAP_LAST = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;
    localparam int unsigned GAP_W    = (GAP_LAST < 2) ? 1 : $clog2(GAP_LAST + 1);

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [15:0]        word_count;

    assign PWRITE    = 1'b0;
    assign PWDATA    = '0;
    assign WORDCOUNT = word_count;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PADDR      <= '0;
            WREN       <= 1'b1;
            DATAOUT    <= '0;
            ERR        <= 1'b0;
            word_count <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ENABLE) begin
                        state   <= FLAG_SETUP;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PADDR   <= BASE_ADDR;
                    end
                end

                FLAG_SETUP: begin
                    state   <= FLAG_ACCESS;
                    PENABLE <= 1'b1;
                end

                FLAG_ACCESS: begin
                    if (PREADY) begin
                        PENABLE <= 1'b0;
                        if (!PSLVERR && !PRDATA[1] && !FULL) begin
                            // PSEL stays high: back-to-back transfer into the data read.
                            state <= DATA_SETUP;
                            PADDR <= BASE_ADDR + 32'd4;
                        end else begin
                            if (PSLVERR) begin
                                ERR <= 1'b1;
                            end
                            state   <= GAP;
                            PSEL    <= 1'b0;
                            gap_cnt <= '0;
                        end
                    end
                end

                DATA_SETUP: begin
                    state   <= DATA_ACCESS;
                    PENABLE <= 1'b1;
                end

                DATA_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            ERR     <= 1'b1;
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            DATAOUT <= PRDATA;
                            state   <= PUSH;
                        end
                    end
                end

                // First edge with FULL low drops WREN; the following edge ends the push.
                PUSH: begin
                    if (!WREN) begin
                        WREN <= 1'b1;
                        if (ENABLE) begin
                            state   <= FLAG_SETUP;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= BASE_ADDR;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!FULL) begin
                        WREN       <= 1'b0;
                        word_count <= word_count + 16'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        if (ENABLE) begin
                            state   <= FLAG_SETUP;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= BASE_ADDR;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    WREN    <= 1'b1;
                end
            endcase
        end
    end

endmodule
